// File: rtl/alu_issue.sv
// Operand-issue/writeback stage for RV32I OP and OP-IMM instructions.
// Decodes, reads the register file, drives an external alu and writes back.
module alu_issue #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_alt,
  input  logic [WIDTH-1:0] alu_result,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             illegal
);

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WRITE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_regs [32];
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [2:0]       r_alu_op;
  logic             r_alu_alt;
  logic [4:0]       r_rd;
  logic [4:0]       r_wb_rd;
  logic [WIDTH-1:0] r_wb_data;
  logic             r_illegal;

  logic [6:0]       w_opc;
  logic [2:0]       w_f3;
  logic [6:0]       w_f7;
  logic [4:0]       w_rs1;
  logic [4:0]       w_rs2;
  logic [4:0]       w_rd;
  logic [WIDTH-1:0] w_rs1_val;
  logic [WIDTH-1:0] w_rs2_val;
  logic [WIDTH-1:0] w_imm;
  logic [WIDTH-1:0] w_shamt;
  logic [WIDTH-1:0] w_b;
  logic             w_alt;
  logic             w_legal;
  logic             w_accept;

  assign w_opc = instr[6:0];
  assign w_rd  = instr[11:7];
  assign w_f3  = instr[14:12];
  assign w_rs1 = instr[19:15];
  assign w_rs2 = instr[24:20];
  assign w_f7  = instr[31:25];

  assign w_imm   = {{(WIDTH-12){instr[31]}}, instr[31:20]};
  assign w_shamt = {{(WIDTH-5){1'b0}}, instr[24:20]};

  assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];

  assign instr_ready = (r_state == S_IDLE);
  assign w_accept    = instr_valid && instr_ready;

  // Shift-immediate forms reuse the funct7 field as a qualifier.
  always_comb begin
    w_legal = 1'b0;
    w_b     = w_imm;
    w_alt   = 1'b0;
    unique case (1'b1)
      (w_opc == OPC_OP): begin
        w_b     = w_rs2_val;
        w_alt   = instr[30];
        w_legal = (w_f7 == F7_ZERO) ||
                  ((w_f7 == F7_ALT) &&
                   ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
      end
      (w_opc == OPC_IMM): begin
        if (w_f3 == 3'b001) begin
          w_b     = w_shamt;
          w_legal = (w_f7 == F7_ZERO);
        end else if (w_f3 == 3'b101) begin
          w_b     = w_shamt;
          w_alt   = instr[30];
          w_legal = (w_f7 == F7_ZERO) || (w_f7 == F7_ALT);
        end else begin
          w_legal = 1'b1;
        end
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept && w_legal) w_next = S_EXEC;
      S_EXEC:  w_next = S_WRITE;
      S_WRITE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= '0;
      r_alu_alt <= 1'b0;
      r_rd      <= '0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= w_accept && !w_legal;
      if (w_accept && w_legal) begin
        r_alu_a   <= w_rs1_val;
        r_alu_b   <= w_b;
        r_alu_op  <= w_f3;
        r_alu_alt <= w_alt;
        r_rd      <= w_rd;
      end
      if (r_state == S_EXEC) begin
        r_wb_data <= alu_result;
        r_wb_rd   <= r_rd;
      end
    end
  end

  // x0 is never written, so it reads back as zero.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if ((r_state == S_WRITE) && (r_wb_rd != 5'd0)) begin
      r_regs[r_wb_rd] <= r_wb_data;
    end
  end

  assign alu_a    = r_alu_a;
  assign alu_b    = r_alu_b;
  assign alu_op   = r_alu_op;
  assign alu_alt  = r_alu_alt;
  assign wb_valid = (r_state == S_WRITE);
  assign wb_rd    = r_wb_rd;
  assign wb_data  = r_wb_data;
  assign illegal  = r_illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: behavioural ALU, instruction-level model,
// per-cycle compare process and directed literal checks.
module tb_alu_issue;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic        alu_alt;
  logic [31:0] alu_result;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  alu_issue #(.WIDTH(32)) dut (
    .CLK(CLK),
    .RST(RST),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_op(alu_op),
    .alu_alt(alu_alt),
    .alu_result(alu_result),
    .wb_valid(wb_valid),
    .wb_rd(wb_rd),
    .wb_data(wb_data),
    .illegal(illegal)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] alu_ref(
    input logic [31:0] a, input logic [31:0] b,
    input logic [2:0] op, input logic alt);
    case (op)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  always_comb alu_result = alu_ref(alu_a, alu_b, alu_op, alu_alt);

  function automatic logic [31:0] enc_i(
    input logic [11:0] imm, input logic [4:0] rs1,
    input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_r(
    input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
    input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  // Instruction-level model: age counts cycles since an accepted legal op.
  logic [31:0] m_regs [32];
  int          m_age;
  int          m_accepts = 0;
  logic        m_ill;
  logic [31:0] m_a, m_b, m_wbd;
  logic [2:0]  m_op;
  logic        m_alt;
  logic [4:0]  m_rd, m_wbrd;

  logic        d_ok;
  logic [31:0] d_b;
  logic        d_alt;

  always_comb begin
    d_ok  = 1'b0;
    d_b   = '0;
    d_alt = 1'b0;
    if (instr[6:0] == 7'b0110011) begin
      d_b   = m_regs[instr[24:20]];
      d_alt = instr[30];
      d_ok  = (instr[31:25] == 7'h00) ||
              (instr[31:25] == 7'h20 && instr[14:12] inside {3'd0, 3'd5});
    end else if (instr[6:0] == 7'b0010011) begin
      d_ok = 1'b1;
      d_b  = 32'($signed(instr[31:20]));
      if (instr[14:12] == 3'd1) begin
        d_b  = {27'd0, instr[24:20]};
        d_ok = (instr[31:25] == 7'h00);
      end else if (instr[14:12] == 3'd5) begin
        d_b   = {27'd0, instr[24:20]};
        d_alt = instr[30];
        d_ok  = instr[31:25] inside {7'h00, 7'h20};
      end
    end
  end

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_age  <= 0;
      m_ill  <= 1'b0;
      m_a    <= '0;
      m_b    <= '0;
      m_op   <= '0;
      m_alt  <= 1'b0;
      m_rd   <= '0;
      m_wbrd <= '0;
      m_wbd  <= '0;
      for (int i = 0; i < 32; i++) m_regs[i] <= '0;
    end else begin
      m_ill <= 1'b0;
      if (m_age == 0 && instr_valid) begin
        m_accepts <= m_accepts + 1;
        if (d_ok) begin
          m_a   <= m_regs[instr[19:15]];
          m_b   <= d_b;
          m_op  <= instr[14:12];
          m_alt <= d_alt;
          m_rd  <= instr[11:7];
          m_age <= 1;
        end else begin
          m_ill <= 1'b1;
        end
      end else if (m_age == 1) begin
        m_wbd  <= alu_ref(m_a, m_b, m_op, m_alt);
        m_wbrd <= m_rd;
        m_age  <= 2;
      end else if (m_age == 2) begin
        if (m_rd != 5'd0) m_regs[m_rd] <= m_wbd;
        m_age <= 0;
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("ready", {31'd0, instr_ready}, {31'd0, m_age == 0});
      chk("wb_valid", {31'd0, wb_valid}, {31'd0, m_age == 2});
      chk("illegal", {31'd0, illegal}, {31'd0, m_ill});
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_op", {29'd0, alu_op}, {29'd0, m_op});
      chk("alu_alt", {31'd0, alu_alt}, {31'd0, m_alt});
      chk("wb_rd", {27'd0, wb_rd}, {27'd0, m_wbrd});
      chk("wb_data", wb_data, m_wbd);
    end
  end

  task automatic wait_accept(input string nm, output bit got);
    int c;
    c   = m_accepts;
    got = 1'b0;
    instr_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (m_accepts != c) begin
        got = 1'b1;
        break;
      end
    end
    instr_valid = 1'b0;
    if (!got) chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
  endtask

  // Called on a negedge; returns on the negedge of the writeback cycle.
  task automatic issue(input string nm, input logic [31:0] ins,
                       input logic legal, input logic [31:0] lit);
    bit got;
    instr = ins;
    wait_accept(nm, got);
    if (got) begin
      if (legal) begin
        chk({nm, "_exec_ill"}, {31'd0, illegal}, 32'd0);
        @(negedge CLK);
        chk({nm, "_wbv"}, {31'd0, wb_valid}, 32'd1);
        chk({nm, "_data"}, wb_data, lit);
      end else begin
        chk({nm, "_ill"}, {31'd0, illegal}, 32'd1);
        chk({nm, "_rdy"}, {31'd0, instr_ready}, 32'd1);
      end
    end
  endtask

  initial begin
    bit got;
    repeat (2) @(negedge CLK);
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_wbv", {31'd0, wb_valid}, 32'd0);
    chk("rst_ill", {31'd0, illegal}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    RST    = 1'b0;
    cmp_en = 1'b1;
    @(negedge CLK);

    instr = enc_i(12'd5, 5'd0, 3'd0, 5'd1);
    wait_accept("addi1", got);
    chk("addi1_a", alu_a, 32'd0);
    chk("addi1_b", alu_b, 32'd5);
    chk("addi1_alt", {31'd0, alu_alt}, 32'd0);
    @(negedge CLK);
    chk("addi1_wbv", {31'd0, wb_valid}, 32'd1);
    chk("addi1_rd", {27'd0, wb_rd}, 32'd1);
    chk("addi1_data", wb_data, 32'd5);

    issue("addi2", enc_i(12'd3, 5'd0, 3'd0, 5'd2), 1'b1, 32'd3);
    issue("sub", enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3), 1'b1, 32'd2);
    chk("sub_alt", {31'd0, alu_alt}, 32'd1);
    issue("slt_a", enc_r(7'h00, 5'd1, 5'd2, 3'd2, 5'd4), 1'b1, 32'd1);
    issue("slt_b", enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd4), 1'b1, 32'd0);
    issue("addi_m1", enc_i(12'hFFF, 5'd0, 3'd0, 5'd5), 1'b1, 32'hFFFFFFFF);
    issue("srli", enc_i(12'h00C, 5'd5, 3'd5, 5'd6), 1'b1, 32'h000FFFFF);
    issue("srai", enc_i(12'h40C, 5'd5, 3'd5, 5'd7), 1'b1, 32'hFFFFFFFF);
    chk("srai_alt", {31'd0, alu_alt}, 32'd1);
    chk("srai_b", alu_b, 32'd12);
    issue("addi_x0", enc_i(12'd7, 5'd0, 3'd0, 5'd0), 1'b1, 32'd7);
    chk("addi_x0_rd", {27'd0, wb_rd}, 32'd0);
    issue("add_x0", enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd8), 1'b1, 32'd0);
    issue("lw", 32'h00002083, 1'b0, 32'd0);
    issue("sub_f3_7", enc_r(7'h20, 5'd2, 5'd1, 3'd7, 5'd4), 1'b0, 32'd0);
    issue("mul", enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd4), 1'b0, 32'd0);
    issue("slli_alt", enc_i(12'h404, 5'd1, 3'd1, 5'd4), 1'b0, 32'd0);
    issue("sltu", enc_r(7'h00, 5'd1, 5'd5, 3'd3, 5'd12), 1'b1, 32'd0);
    issue("or", enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd13), 1'b1, 32'd7);
    issue("slli", enc_i(12'h004, 5'd1, 3'd1, 5'd14), 1'b1, 32'h50);
    issue("andi", enc_i(12'hFF0, 5'd5, 3'd7, 5'd15), 1'b1, 32'hFFFFFFF0);
    issue("addi_neg", enc_i(12'hC00, 5'd0, 3'd0, 5'd16), 1'b1, 32'hFFFFFC00);
    chk("addi_neg_alt", {31'd0, alu_alt}, 32'd0);
    issue("xor_chk", enc_r(7'h00, 5'd16, 5'd15, 3'd4, 5'd17), 1'b1, 32'h000003F0);

    @(negedge CLK);
    instr = enc_i(12'd9, 5'd0, 3'd0, 5'd9);
    wait_accept("addi9", got);
    chk("addi9_b", alu_b, 32'd9);
    #2 RST = 1'b1;
    @(negedge CLK);
    chk("rst_mid_wbv", {31'd0, wb_valid}, 32'd0);
    chk("rst_mid_rdy", {31'd0, instr_ready}, 32'd1);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_wbv", {31'd0, wb_valid}, 32'd0);
    issue("rd_x9", enc_r(7'h00, 5'd9, 5'd9, 3'd0, 5'd10), 1'b1, 32'd0);
    issue("rd_x1", enc_r(7'h00, 5'd0, 5'd1, 3'd0, 5'd10), 1'b1, 32'd0);
    @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
